// File: rtl/tape_adc_slicer_pkg.sv
// Shared constants, FSM state encoding and accumulator type for the cassette ADC slicer.
package tape_pkg;

   localparam int ADC_W        = 12;
   localparam int AVG_LOG2_DEF = 9;
   localparam int HYST_DEF     = 100;
   localparam int ACC_W_DEF    = ADC_W + AVG_LOG2_DEF;

   typedef logic [ACC_W_DEF-1:0] acc_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      ACC   = 2'd2,
      SLICE = 2'd3
   } slicer_state_e;

endpackage

// File: rtl/tape_adc_slicer_avg_ring.sv
// Circular sample store for the running average: simple dual-port RAM with a
// registered read port that returns the old word on read-during-write.
module tape_avg_ring
   import tape_pkg::*;
#(
   parameter int DATA_W = ADC_W,
   parameter int ADDR_W = AVG_LOG2_DEF
)(
   input  logic              clk_sys,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] rd_data_q;

   // RAM write port and registered read port; contents are never reset
   always_ff @(posedge clk_sys) begin
      if (we) begin
         mem_q[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/tape_adc_slicer.sv
// Cassette ADC slicer: running-average reference, hysteresis slicing and warm-up gating.
// Define TAPE_SLICER_DEGLITCH_EN to require GLITCH_N agreeing slices before cass_bit flips.
module tape_adc_slicer
   import tape_pkg::*;
#(
   parameter int DATA_W   = ADC_W,
   parameter int AVG_LOG2 = AVG_LOG2_DEF,
   parameter int HYST     = HYST_DEF,
   parameter int GLITCH_N = 3
)(
   input  logic              clk_sys,
   input  logic              reset,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              adc_sync,
   output logic              cass_bit,
   output logic              bit_edge,
   output logic              sample_stb,
   output logic [DATA_W-1:0] avg,
   output logic              valid,
   output logic              overrun
);

   localparam int ACC_W = DATA_W + AVG_LOG2;
   localparam int SW    = DATA_W + 2;
   localparam logic [AVG_LOG2:0]        WIN      = {1'b1, {AVG_LOG2{1'b0}}};
   localparam logic [AVG_LOG2:0]        FILL_ONE = {{AVG_LOG2{1'b0}}, 1'b1};
   localparam logic [AVG_LOG2-1:0]      PTR_ONE  = {{(AVG_LOG2-1){1'b0}}, 1'b1};
   localparam logic signed [SW-1:0]     HYST_S   = SW'(HYST);

   slicer_state_e       state_q, state_d;
   logic                sync_q;
   logic [DATA_W-1:0]   samp_q, samp_d;
   logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [AVG_LOG2:0]   fill_q, fill_d;
   logic [ACC_W-1:0]    total_q, total_d;
   logic [DATA_W-1:0]   avg_q, avg_d;
   logic                valid_q, valid_d;
   logic                cand_q, cand_d;
   logic                cass_q, cass_d;
   logic                bit_edge_q, bit_edge_d;
   logic                sample_stb_q, sample_stb_d;
   logic                overrun_q, overrun_d;
`ifdef TAPE_SLICER_DEGLITCH_EN
   localparam int RUN_W = $clog2(GLITCH_N + 1);
   localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(GLITCH_N);
   logic [RUN_W-1:0]    run_q, run_d, run_inc_s;
`endif

   logic                toggle_s, valid_new_s, cand_new_s;
   logic [DATA_W-1:0]   ram_q, oldest_s, avg_new_s;
   logic signed [SW-1:0] avg_sx_s, lo_s, hi_s, samp_sx_s;

   tape_avg_ring #(.DATA_W(DATA_W), .ADDR_W(AVG_LOG2)) u_ring (
      .clk_sys (clk_sys),
      .we      (state_q == ACC),
      .wr_addr (wr_ptr_q),
      .wr_data (samp_q),
      .rd_en   (state_q == READ),
      .rd_addr (wr_ptr_q),
      .rd_data (ram_q)
   );

   assign toggle_s    = adc_sync ^ sync_q;
   assign valid_new_s = (fill_q == WIN);
   assign oldest_s    = (fill_q < WIN) ? {DATA_W{1'b0}} : ram_q;
   assign avg_new_s   = total_q[ACC_W-1:AVG_LOG2];
   // Two extra sign bits keep avg-HYST negative near zero instead of wrapping
   assign avg_sx_s    = $signed({2'b00, avg_new_s});
   assign samp_sx_s   = $signed({2'b00, samp_q});
   assign lo_s        = avg_sx_s - HYST_S;
   assign hi_s        = avg_sx_s + HYST_S;

   // State register and all datapath flops
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q      <= IDLE;
         sync_q       <= 1'b0;
         samp_q       <= {DATA_W{1'b0}};
         wr_ptr_q     <= {AVG_LOG2{1'b0}};
         fill_q       <= {(AVG_LOG2+1){1'b0}};
         total_q      <= {ACC_W{1'b0}};
         avg_q        <= {DATA_W{1'b0}};
         valid_q      <= 1'b0;
         cand_q       <= 1'b0;
         cass_q       <= 1'b0;
         bit_edge_q   <= 1'b0;
         sample_stb_q <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef TAPE_SLICER_DEGLITCH_EN
         run_q        <= {RUN_W{1'b0}};
`endif
      end else begin
         state_q      <= state_d;
         sync_q       <= adc_sync;
         samp_q       <= samp_d;
         wr_ptr_q     <= wr_ptr_d;
         fill_q       <= fill_d;
         total_q      <= total_d;
         avg_q        <= avg_d;
         valid_q      <= valid_d;
         cand_q       <= cand_d;
         cass_q       <= cass_d;
         bit_edge_q   <= bit_edge_d;
         sample_stb_q <= sample_stb_d;
         overrun_q    <= overrun_d;
`ifdef TAPE_SLICER_DEGLITCH_EN
         run_q        <= run_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (toggle_s) state_d = READ; else state_d = IDLE;
         READ:    state_d = ACC;
         ACC:     state_d = SLICE;
         SLICE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Slice candidate: below lo -> 1, above hi -> 0, otherwise hold
   always_comb begin
      if (samp_sx_s < lo_s) begin
         cand_new_s = 1'b1;
      end else if (samp_sx_s > hi_s) begin
         cand_new_s = 1'b0;
      end else begin
         cand_new_s = cand_q;
      end
   end

`ifdef TAPE_SLICER_DEGLITCH_EN
   assign run_inc_s = run_q + RUN_ONE;
`endif

   // Datapath and output updates per state
   always_comb begin
      samp_d       = samp_q;
      wr_ptr_d     = wr_ptr_q;
      fill_d       = fill_q;
      total_d      = total_q;
      avg_d        = avg_q;
      valid_d      = valid_q;
      cand_d       = cand_q;
      cass_d       = cass_q;
      bit_edge_d   = 1'b0;
      sample_stb_d = 1'b0;
      overrun_d    = overrun_q | (toggle_s & (state_q != IDLE));
`ifdef TAPE_SLICER_DEGLITCH_EN
      run_d        = run_q;
`endif
      case (state_q)
         IDLE: begin
            if (toggle_s) samp_d = adc_data; else samp_d = samp_q;
         end
         READ: begin
            samp_d = samp_q;
         end
         ACC: begin
            total_d  = total_q - {{AVG_LOG2{1'b0}}, oldest_s} + {{AVG_LOG2{1'b0}}, samp_q};
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (fill_q < WIN) fill_d = fill_q + FILL_ONE; else fill_d = fill_q;
         end
         SLICE: begin
            avg_d        = avg_new_s;
            valid_d      = valid_new_s;
            cand_d       = cand_new_s;
            sample_stb_d = 1'b1;
`ifdef TAPE_SLICER_DEGLITCH_EN
            if (!valid_new_s) begin
               cass_d = 1'b0;
               run_d  = {RUN_W{1'b0}};
            end else if (cand_new_s == cass_q) begin
               cass_d = cass_q;
               run_d  = {RUN_W{1'b0}};
            end else if (run_inc_s >= RUN_MAX) begin
               cass_d = cand_new_s;
               run_d  = {RUN_W{1'b0}};
            end else begin
               cass_d = cass_q;
               run_d  = run_inc_s;
            end
`else
            if (valid_new_s) cass_d = cand_new_s; else cass_d = 1'b0;
`endif
            bit_edge_d = cass_d ^ cass_q;
         end
         default: begin
            samp_d = samp_q;
         end
      endcase
   end

   assign cass_bit   = cass_q;
   assign bit_edge   = bit_edge_q;
   assign sample_stb = sample_stb_q;
   assign avg        = avg_q;
   assign valid      = valid_q;
   assign overrun    = overrun_q;

endmodule

// File: doc/tape_adc_slicer.md
Name: tape_adc_slicer

Overview:
- Turns raw ltc2308 ADC samples into a clean cassette data bit.
- Sits between the ADC framework interface and the mc10 `cin` input and tape overlay, replacing the inline slicer logic in the top level.
- Keeps a running average over 2^AVG_LOG2 samples in a circular RAM; the average acts as a DC/high-pass reference.
- Slices each sample against average ± hysteresis, with sign-safe arithmetic, warm-up qualification and overrun detection.

Parameters:
- DATA_W, 12, ADC sample width.
- AVG_LOG2, 9, log2 of averaging window; window = 512 samples.
- HYST, 100, hysteresis offset in ADC LSBs (≈0.1 V).
- GLITCH_N, 3, consecutive agreeing samples required before the output flips (deglitch build only).

Ports:
- clk_sys  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- adc_data  in  DATA_W  ADC sample; stable whenever adc_sync toggles.
- adc_sync  in  1  toggles once per new sample (ltc2308 dout_sync).
- cass_bit  out  1  sliced tape bit; 1 = sample below average (CoCo/MC-10 inverted polarity).
- bit_edge  out  1  one-cycle pulse when cass_bit changes.
- sample_stb  out  1  one-cycle pulse when a sample's slice result is committed.
- avg  out  DATA_W  current window average.
- valid  out  1  high once the window is full.
- overrun  out  1  sticky; set when a sample arrives while the pipeline is busy.

Behaviour:
- Reset values: cass_bit=0, bit_edge=0, sample_stb=0, avg=0, valid=0, overrun=0; also wr_ptr=0, fill count=0, total=0, sync_d=0, state=IDLE. RAM contents are not cleared.
- Sample detect: sync_d registers adc_sync every cycle. A toggle (adc_sync ^ sync_d) in IDLE latches adc_data into `samp` and moves to READ.
- FSM: IDLE -> READ -> ACC -> SLICE -> IDLE. One cycle per state, so latency is toggle-detect + 3 cycles to sample_stb.
  - READ: issue RAM read at wr_ptr (oldest sample).
  - ACC:
    - oldest = (fill < 2^AVG_LOG2) ? 0 : ram_q.
    - total <= total − oldest + samp. total is DATA_W+AVG_LOG2 bits (21) and never over/underflows.
    - Write samp to RAM at wr_ptr.
    - wr_ptr <= wr_ptr+1, wrapping modulo 2^AVG_LOG2.
    - fill saturates at 2^AVG_LOG2.
  - SLICE:
    - avg <= total >> AVG_LOG2, using the new total.
    - lo = avg_new − HYST, hi = avg_new + HYST, evaluated in signed DATA_W+2 bits. No wrap: avg=50 gives lo=−50, never 4046.
    - samp < lo sets the candidate to 1; samp > hi sets it to 0; otherwise the candidate holds.
    - sample_stb=1.
    - valid <= (fill == 2^AVG_LOG2).
- Warm-up: while valid=0, cass_bit is forced to 0 and the candidate is still tracked. On the first valid SLICE, cass_bit takes the candidate value.
- bit_edge pulses in the same cycle cass_bit changes value, including the first valid cycle if the candidate is 1.
- Simultaneous events:
  - A toggle in READ/ACC/SLICE is dropped and sets overrun. Cleared only by reset.
  - A toggle in the same cycle the FSM returns to IDLE is accepted.
- Reset mid-operation: the FSM returns to IDLE, fill=0, total=0, and any in-flight sample is discarded.

Optional Feature:
- TAPE_SLICER_DEGLITCH_EN defined:
  - cass_bit changes only after the candidate has differed from cass_bit for GLITCH_N consecutive SLICE events.
  - The run counter resets whenever the candidate equals cass_bit.
- Undefined: cass_bit follows the candidate directly.
- Warm-up forcing applies in both builds.

Decomposition:
- Package tape_pkg:
  - ADC_W=12, AVG_LOG2_DEF=9, HYST_DEF=100.
  - Slicer FSM state enum (IDLE, READ, ACC, SLICE).
  - Typedef for the accumulator width.
- Sub-module tape_avg_ring:
  - Single-clock simple dual-port RAM, 2^AVG_LOG2 × DATA_W.
  - Registered read, one-cycle latency.
  - Read-during-write to the same address returns old data.

Test Plan:
- Reset, then 512 toggles at constant 2048 -> valid rises on 512th sample_stb, avg=2048, cass_bit=0, no bit_edge, overrun=0.
- After fill at 2048, sample 1900 -> cass_bit=1 with one bit_edge. Then 2100 (avg ≈2048, within hysteresis) -> holds 1. Then 2200 -> cass_bit=0.
- Fill with 50, then inject 0 -> lo computed as negative, cass_bit stays 0; no wrap-induced false 1.
- Toggle adc_sync twice 2 cycles apart -> second sample dropped, overrun=1 and sticky; first sample's sample_stb occurs 3 cycles after its toggle was detected.
- Assert reset in ACC state -> next cycle all outputs at reset values; 511 further samples leave valid=0.
- Deglitch build, GLITCH_N=3, valid state cass_bit=0: sample pattern low,low,high,low,low,low -> cass_bit=1 only on the 6th sample_stb. Non-deglitch build -> flips on the 1st.
